// File: rtl/ps2_cmd_scheduler.sv
// Arbitrates CPU and LED-update commands onto the PS/2 host-to-keyboard path,
// waits for the keyboard ACK (FA), handles resend (FE) and timeouts with bounded retries.
module ps2_cmd_scheduler #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_400_000,
  parameter logic [1:0]  MAX_RETRIES    = 2'd3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cpu_wr_i,
  input  logic [7:0] cpu_data_i,
  output logic       cpu_busy_o,
  input  logic       led_req_i,
  input  logic [2:0] led_state_i,
  output logic [7:0] tx_data_o,
  output logic       tx_load_o,
  input  logic       tx_busy_i,
  input  logic       tx_error_i,
  input  logic       rx_new_i,
  input  logic [7:0] rx_code_i,
  output logic       done_ok_o,
  output logic       done_fail_o,
  output logic       fail_owner_o
);

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic       OWNER_CPU    = 1'b0;
  localparam logic       OWNER_LED    = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_TXSTART, S_TXDONE, S_ACK, S_RETRY, S_END_OK, S_END_FAIL
  } state_e;

  state_e      state_q;
  logic        cpu_pend_q;
  logic [7:0]  cpu_byte_q;
  logic        led_pend_q;
  logic        owner_q;
  logic        idx_q;
  logic [1:0]  retry_q;
  logic [23:0] tmo_q;
  logic [7:0]  tx_data_q;
  logic        tx_load_q;
  logic        done_ok_q;
  logic        done_fail_q;
  logic        fail_owner_q;

  logic        tmo_hit_s;
  logic        last_byte_s;

  // Byte for a given owner and position: CPU sends its latched byte, LED sends ED then the mask.
  function automatic logic [7:0] pick_byte(input logic owner, input logic idx,
                                           input logic [7:0] cpu_b, input logic [2:0] leds);
    if (owner == OWNER_CPU) begin
      return cpu_b;
    end else if (idx == 1'b0) begin
      return CMD_SET_LEDS;
    end else begin
      return {5'b00000, leds};
    end
  endfunction

  // Wait-phase timeout and end-of-sequence detection.
  always_comb begin
    tmo_hit_s   = (tmo_q == (TIMEOUT_CYCLES - 24'd1));
    last_byte_s = (owner_q == OWNER_CPU) ? 1'b1 : idx_q;
  end

  // Request capture and command sequencing FSM; all outputs registered here.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      cpu_pend_q   <= 1'b0;
      cpu_byte_q   <= 8'h00;
      led_pend_q   <= 1'b0;
      owner_q      <= OWNER_CPU;
      idx_q        <= 1'b0;
      retry_q      <= 2'd0;
      tmo_q        <= 24'd0;
      tx_data_q    <= 8'h00;
      tx_load_q    <= 1'b0;
      done_ok_q    <= 1'b0;
      done_fail_q  <= 1'b0;
      fail_owner_q <= 1'b0;
    end else begin
      tx_load_q   <= 1'b0;
      done_ok_q   <= 1'b0;
      done_fail_q <= 1'b0;

      if (cpu_wr_i && !cpu_pend_q) begin
        cpu_pend_q <= 1'b1;
        cpu_byte_q <= cpu_data_i;
      end
      if (led_req_i) begin
        led_pend_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (cpu_pend_q) begin
            owner_q   <= OWNER_CPU;
            idx_q     <= 1'b0;
            retry_q   <= 2'd0;
            tx_data_q <= cpu_byte_q;
            tx_load_q <= 1'b1;
            state_q   <= S_LOAD;
          end else if (led_pend_q) begin
            // A pulse arriving on the grant cycle must survive as a new request.
            led_pend_q <= led_req_i;
            owner_q    <= OWNER_LED;
            idx_q      <= 1'b0;
            retry_q    <= 2'd0;
            tx_data_q  <= CMD_SET_LEDS;
            tx_load_q  <= 1'b1;
            state_q    <= S_LOAD;
          end
        end
        S_LOAD: begin
          tmo_q   <= 24'd0;
          state_q <= S_TXSTART;
        end
        S_TXSTART: begin
          if (tx_busy_i) begin
            tmo_q   <= 24'd0;
            state_q <= S_TXDONE;
          end else if (tmo_hit_s) begin
            state_q <= S_RETRY;
          end else begin
            tmo_q <= tmo_q + 24'd1;
          end
        end
        S_TXDONE: begin
          if (!tx_busy_i) begin
            tmo_q   <= 24'd0;
            state_q <= tx_error_i ? S_RETRY : S_ACK;
          end else if (tmo_hit_s) begin
            state_q <= S_RETRY;
          end else begin
            tmo_q <= tmo_q + 24'd1;
          end
        end
        S_ACK: begin
          if (rx_new_i && (rx_code_i == RSP_ACK)) begin
            if (last_byte_s) begin
              done_ok_q    <= 1'b1;
              fail_owner_q <= owner_q;
              state_q      <= S_END_OK;
            end else begin
              idx_q     <= 1'b1;
              retry_q   <= 2'd0;
              tx_data_q <= pick_byte(owner_q, 1'b1, cpu_byte_q, led_state_i);
              tx_load_q <= 1'b1;
              state_q   <= S_LOAD;
            end
          end else if (rx_new_i && (rx_code_i == RSP_RESEND)) begin
            state_q <= S_RETRY;
          end else if (tmo_hit_s) begin
            state_q <= S_RETRY;
          end else begin
            tmo_q <= tmo_q + 24'd1;
          end
        end
        S_RETRY: begin
          if (retry_q == MAX_RETRIES) begin
            done_fail_q  <= 1'b1;
            fail_owner_q <= owner_q;
            state_q      <= S_END_FAIL;
          end else begin
            retry_q   <= retry_q + 2'd1;
            tx_data_q <= pick_byte(owner_q, idx_q, cpu_byte_q, led_state_i);
            tx_load_q <= 1'b1;
            state_q   <= S_LOAD;
          end
        end
        S_END_OK, S_END_FAIL: begin
          if (owner_q == OWNER_CPU) begin
            cpu_pend_q <= 1'b0;
          end
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu_busy_o   = cpu_pend_q;
  assign tx_data_o    = tx_data_q;
  assign tx_load_o    = tx_load_q;
  assign done_ok_o    = done_ok_q;
  assign done_fail_o  = done_fail_q;
  assign fail_owner_o = fail_owner_q;

endmodule

// File: doc/ps2_cmd_scheduler.md
Name: ps2_cmd_scheduler

Overview:
- Sequences host-to-keyboard commands on the single PS/2 transmit path (ps2_host_to_kb) and checks the keyboard's replies arriving through the receive path (ps2_port kb_interrupt/scancode).
- Two requesters share the path:
  - CPU single-byte commands, written through the SCANCODE register.
  - An internal LED-update requester that emits the two-byte sequence ED, LED-mask.
- Handles ACK (FA), resend (FE), timeouts and a bounded retry count, and reports success or failure per transaction.

Parameters:
- TIMEOUT_CYCLES, 24'd1_400_000: cycles allowed per wait phase before the byte is retried (about 50 ms at 28 MHz).
- MAX_RETRIES, 2'd3: retransmissions allowed per byte before the sequence is aborted.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: synchronous reset, active low.
- cpu_wr, input, 1: one-cycle pulse; CPU command byte is valid on cpu_data.
- cpu_data, input, 8: CPU command byte.
- cpu_busy, output, 1: CPU byte is pending or in flight.
- led_req, input, 1: one-cycle pulse requesting an LED update.
- led_state, input, 3: {caps, num, scroll}. Sampled when the LED data byte is loaded.
- tx_data, output, 8: byte to transmit; drives ps2_host_to_kb data.
- tx_load, output, 1: one-cycle load strobe; drives ps2_host_to_kb dataload.
- tx_busy, input, 1: ps2busy from the transmitter.
- tx_error, input, 1: ps2error from the transmitter; sampled when tx_busy falls.
- rx_new, input, 1: kb_interrupt pulse from the receiver.
- rx_code, input, 8: received scancode; valid while rx_new is high.
- done_ok, output, 1: one-cycle pulse when a whole sequence has been ACKed.
- done_fail, output, 1: one-cycle pulse when a sequence is aborted.
- fail_owner, output, 1: 0 = CPU, 1 = LED. Updated with done_ok or done_fail.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Outputs: cpu_busy=0, tx_load=0, tx_data=00, done_ok=0, done_fail=0, fail_owner=0.
  - Internal: state=IDLE, both pending flags cleared, retry counter=0, timeout counter=0.
  - Reset mid-transaction abandons the transaction silently: no done pulse, no further tx_load.
- CPU request:
  - cpu_wr is accepted only if cpu_busy=0 in the same cycle. An accepted byte is latched and cpu_busy=1 from the next cycle.
  - cpu_wr while cpu_busy=1 is ignored.
  - cpu_busy drops in the cycle after done_ok or done_fail for a CPU sequence.
- LED request:
  - led_req sets led_pend. It is coalesced: repeated pulses before the grant produce one sequence.
  - led_req arriving during an LED sequence re-sets led_pend, so one more sequence follows.
- Arbitration, evaluated in IDLE:
  - CPU has priority over LED.
  - A granted sequence runs to completion or abort without interleaving.
  - led_pend clears at grant; the CPU pending flag clears at sequence end.
- FSM states:
  - IDLE: if a request is pending, grant it, set byte index=0, retry=0, go to LOAD.
  - LOAD: for one cycle, drive tx_data and tx_load=1, then go to TXSTART.
    - CPU sequence: the latched cpu_data byte.
    - LED sequence: index 0 is ED; index 1 is {5'b0, led_state}.
  - TXSTART: wait for tx_busy=1, then go to TXDONE. Timeout leads to RETRY.
  - TXDONE: wait for tx_busy=0, then go to ACK. If tx_error=1 on that cycle, go to RETRY instead. Timeout leads to RETRY.
  - ACK: wait for rx_new=1.
    - rx_code=FA: if this was the last byte, go to END_OK; otherwise increment the index, set retry=0, go to LOAD.
    - rx_code=FE: go to RETRY.
    - Any other code: ignore and keep waiting.
    - Timeout leads to RETRY.
  - RETRY: if retry==MAX_RETRIES, go to END_FAIL; otherwise increment retry and go to LOAD with the same byte.
  - END_OK: pulse done_ok for one cycle, go to IDLE.
  - END_FAIL: pulse done_fail for one cycle, go to IDLE. The remaining bytes of the sequence are not sent.
- Timeout counter:
  - Clears on entry to TXSTART, TXDONE and ACK.
  - Timeout fires when the count reaches TIMEOUT_CYCLES-1.
- Simultaneous events:
  - rx_new on the same cycle TXDONE leaves is not seen; the ACK window opens the cycle after.
  - cpu_wr and led_req in the same IDLE cycle: CPU is served first, LED next.
- Latency: tx_load is asserted 2 cycles after an accepted cpu_wr in IDLE (IDLE to LOAD, then the LOAD cycle).
- Total transmissions per byte are at most MAX_RETRIES+1.

Test Plan:
- CPU path: cpu_wr with data FF; keyboard model raises tx_busy for 100 cycles, then returns FA.
  - Required: exactly one tx_load, with tx_data=FF.
  - Required: done_ok=1 with fail_owner=0; cpu_busy falls the next cycle.
- LED path: led_state=3'b101, led_req; model ACKs each byte.
  - Required: tx_load with ED, then tx_load with 05; one done_ok with fail_owner=1.
- Resend and abort: CPU byte F4; model answers FE each time.
  - Required: 4 tx_loads of F4, then done_fail.
  - Model answers FE, FE, FA instead: 3 tx_loads, then done_ok.
- Timeouts and errors, with TIMEOUT_CYCLES=100:
  - No reply after the transmit: retries occur at 100-cycle intervals, and done_fail follows the 4th attempt.
  - tx_error=1 at the tx_busy fall also triggers a retry.
- Arbitration: cpu_wr(EE) and led_req in the same cycle.
  - Required: EE is sent and ACKed before ED.
  - A second cpu_wr issued while busy is dropped.
  - Two led_req pulses before the grant yield one LED sequence.
- Reset: assert rst_n=0 for 1 cycle while in ACK.
  - Required: no done pulse, cpu_busy=0, tx_load=0.
  - A subsequent FA is ignored, and a new cpu_wr is accepted normally.
